// File: rtl/mssd_pkg.sv
// Shared types and helpers for the parametrised serial demultiplexer.
package mssd_pkg;

  // END is not a state: frame completion is folded into the last sampling edge.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    PAR  = 3'd4
  } state_t;

  function automatic int cnt_width(input int addr_w, input int len_w);
    return (addr_w > len_w) ? addr_w : len_w;
  endfunction

endpackage

// File: rtl/mssd_param_if.sv
// Bundle of the serial input and the decoded channel outputs of mssd_param.
interface mssd_param_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = $clog2(NUM_CH)
);
  import mssd_pkg::*;

  // outValid qualifies p for exactly the cycle it is high; there is no
  // back-pressure, so a consumer must take each payload bit as it appears.
  logic              serIn;
  logic [ADDR_W-1:0] d;
  logic [NUM_CH-1:0] p;
  logic              outValid;
  logic              error;
  logic              frame_done;
  logic              busy;
  state_t            state;

  modport master (
    output serIn,
    input  d, p, outValid, error, frame_done, busy, state
  );

  modport slave (
    input  serIn,
    output d, p, outValid, error, frame_done, busy, state
  );

endinterface

// File: rtl/mssd_frame_counter.sv
// Loadable down-counter with terminal-count flag; saturates at zero.
module mssd_frame_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == '0);

endmodule

// File: rtl/mssd_param.sv
// Framed serial-to-one-hot demultiplexer: start bit, address, length, payload
// and optional even-parity trailer, with per-frame done/error strobes.
module mssd_param
  import mssd_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int LEN_W     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  mssd_param_if.slave  bus
);

  localparam int ADDR_W = $clog2(NUM_CH);
  localparam int CW     = cnt_width(ADDR_W, LEN_W);

  state_t            state_q, state_d;
  logic [CW-1:0]     sh_q, sh_d;
  logic [ADDR_W-1:0] d_q, d_d;
  logic [NUM_CH-1:0] p_q, p_d;
  logic              out_valid_q, out_valid_d;
  logic              error_q, error_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              par_q, par_d;

  logic              cnt_load, cnt_dec, cnt_tc;
  logic [CW-1:0]     cnt_val;
  logic [CW-1:0]     sh_next;
  logic [LEN_W-1:0]  len_next;
  logic              addr_oor;
  logic              frame_end;
  logic              par_fail;

  mssd_frame_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    d_d          = d_q;
    p_d          = '0;
    out_valid_d  = 1'b0;
    error_d      = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    par_d        = par_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_val      = '0;
    frame_end    = 1'b0;
    par_fail     = 1'b0;

    // Fields arrive MSB first; only the low field-width bits are ever used.
    sh_next  = (sh_q << 1) | CW'(bus.serIn);
    len_next = sh_next[LEN_W-1:0];
    addr_oor = (int'(d_q) >= NUM_CH);

    case (state_q)
      IDLE: begin
        if (!bus.serIn) begin
          state_d  = ADDR;
          busy_d   = 1'b1;
          sh_d     = '0;
          par_d    = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = CW'(ADDR_W - 1);
        end
      end

      ADDR: begin
        sh_d  = sh_next;
        par_d = par_q ^ bus.serIn;
        if (cnt_tc) begin
          d_d      = sh_next[ADDR_W-1:0];
          state_d  = LEN;
          cnt_load = 1'b1;
          cnt_val  = CW'(LEN_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end

      LEN: begin
        sh_d  = sh_next;
        par_d = par_q ^ bus.serIn;
        if (cnt_tc) begin
          if (len_next != '0) begin
            state_d  = DATA;
            cnt_load = 1'b1;
            cnt_val  = CW'(len_next) - CW'(1);
          end else if (PARITY_EN != 0) begin
            state_d = PAR;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      DATA: begin
        par_d = par_q ^ bus.serIn;
        // Out-of-range destinations still consume their payload, silently.
        if (!addr_oor) begin
          p_d[d_q]    = bus.serIn;
          out_valid_d = 1'b1;
        end
        if (cnt_tc) begin
          if (PARITY_EN != 0) begin
            state_d = PAR;
          end else begin
            frame_end = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      PAR: begin
        par_fail  = par_q ^ bus.serIn;
        frame_end = 1'b1;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Returning straight to IDLE lets a start bit on the next edge begin a new frame.
    if (frame_end) begin
      state_d      = IDLE;
      busy_d       = 1'b0;
      frame_done_d = 1'b1;
      error_d      = addr_oor | par_fail;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      d_q          <= '0;
      p_q          <= '0;
      out_valid_q  <= 1'b0;
      error_q      <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      par_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      d_q          <= d_d;
      p_q          <= p_d;
      out_valid_q  <= out_valid_d;
      error_q      <= error_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      par_q        <= par_d;
    end
  end

  assign bus.d          = d_q;
  assign bus.p          = p_q;
  assign bus.outValid   = out_valid_q;
  assign bus.error      = error_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mssd_param.sv
// Bench for mssd_param: a 4-channel and a 3-channel instance driven with
// table frames, back-to-back frames, an out-of-range address and a mid-frame reset.
module tb_mssd_param;
  import mssd_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mssd_param_if #(.NUM_CH(4)) if4 ();
  mssd_param_if #(.NUM_CH(3)) if3 ();

  mssd_param #(.NUM_CH(4), .LEN_W(4), .PARITY_EN(1)) u4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  mssd_param #(.NUM_CH(3), .LEN_W(4), .PARITY_EN(1)) u3 (
    .clk (clk),
    .rst (rst),
    .bus (if3.slave)
  );

  typedef struct {
    logic [1:0]  addr;
    logic [3:0]  n;
    logic [14:0] pay;
    logic        bad_par;
    logic        exp_err;
  } vec_t;

  vec_t tab[8];

  int n_checks = 0;
  int n_pass   = 0;
  logic sb_en  = 1'b0;
  int vcount   = 0;

  // Scoreboard: {d, p} per payload cycle, {d, error, n} per frame.
  logic [5:0] data_exp_q[$];
  logic [6:0] frame_exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 0) if4.serIn = b;
    else if3.serIn = b;
  endtask

  task automatic rd(input int sel, output logic v, output logic [3:0] pv, output logic [1:0] dv,
                    output logic err, output logic fd, output logic bsy);
    if (sel == 0) begin
      v = if4.outValid; pv = if4.p; dv = if4.d;
      err = if4.error; fd = if4.frame_done; bsy = if4.busy;
    end else begin
      v = if3.outValid; pv = {1'b0, if3.p}; dv = if3.d;
      err = if3.error; fd = if3.frame_done; bsy = if3.busy;
    end
  endtask

  task automatic send_frame(input int sel, input logic [1:0] addr, input logic [3:0] n,
                            input logic [14:0] pay, input logic bad_par, input logic exp_err);
    logic bits[$];
    logic par, in_rng, is_pay, last;
    logic v, err, fd, bsy;
    logic [3:0] pv, onehot;
    logic [1:0] dv;
    int len;
    bits.push_back(1'b0);
    bits.push_back(addr[1]);
    bits.push_back(addr[0]);
    for (int i = 3; i >= 0; i--) bits.push_back(n[i]);
    par = (^addr) ^ (^n);
    for (int i = int'(n) - 1; i >= 0; i--) begin
      bits.push_back(pay[i]);
      par = par ^ pay[i];
    end
    bits.push_back(par ^ bad_par);
    in_rng = (sel == 0) || (addr != 2'd3);
    onehot = 4'b0001 << addr;
    if (sel == 0) begin
      for (int i = int'(n) - 1; i >= 0; i--)
        data_exp_q.push_back({addr, pay[i] ? onehot : 4'b0000});
      frame_exp_q.push_back({addr, exp_err, n});
    end
    len = bits.size();
    for (int i = 0; i < len; i++) begin
      drive(sel, bits[i]);
      @(posedge clk);
      #1;
      rd(sel, v, pv, dv, err, fd, bsy);
      is_pay = (i >= 7) && (i < 7 + int'(n));
      last   = (i == len - 1);
      chk("busy", 32'(bsy), 32'(!last));
      chk("out_valid", 32'(v), 32'(is_pay && in_rng));
      chk("p", 32'(pv), (is_pay && in_rng && bits[i]) ? 32'(onehot) : 32'd0);
      chk("frame_done", 32'(fd), 32'(last));
      chk("error", 32'(err), last ? 32'(exp_err) : 32'd0);
      if (i >= 2) chk("d", 32'(dv), 32'(addr));
    end
  endtask

  task automatic idle(input int k);
    if4.serIn = 1'b1;
    if3.serIn = 1'b1;
    repeat (k) begin
      @(posedge clk);
      #1;
      chk("idle_frame_done", 32'(if4.frame_done), 32'd0);
      chk("idle_busy", 32'(if4.busy), 32'd0);
    end
  endtask

  // Output monitor for the 4-channel instance.
  always @(negedge clk) begin
    logic [5:0] de;
    logic [6:0] fe;
    if (!rst) begin
      vcount = 0;
    end else if (sb_en) begin
      if (if4.outValid) begin
        chk("data_pending", 32'(data_exp_q.size() > 0), 32'd1);
        if (data_exp_q.size() > 0) begin
          de = data_exp_q.pop_front();
          chk("sb_data", 32'({if4.d, if4.p}), 32'(de));
        end
        vcount++;
      end else begin
        chk("p_idle", 32'(if4.p), 32'd0);
      end
      if (if4.frame_done) begin
        chk("frame_pending", 32'(frame_exp_q.size() > 0), 32'd1);
        if (frame_exp_q.size() > 0) begin
          fe = frame_exp_q.pop_front();
          chk("sb_frame", 32'({if4.d, if4.error, 4'(vcount)}), 32'(fe));
        end
        vcount = 0;
      end else begin
        chk("error_stray", 32'(if4.error), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    if4.serIn = 1'b1;
    if3.serIn = 1'b1;

    tab[0] = '{2'd1, 4'd3,  15'b101,  1'b0, 1'b0};
    tab[1] = '{2'd1, 4'd3,  15'b101,  1'b1, 1'b1};
    tab[2] = '{2'd2, 4'd0,  15'd0,    1'b0, 1'b0};
    tab[3] = '{2'd3, 4'd1,  15'b1,    1'b0, 1'b0};
    tab[4] = '{2'd0, 4'd2,  15'b11,   1'b0, 1'b0};
    tab[5] = '{2'd0, 4'd15, 15'($urandom_range(0, 32767)), 1'b0, 1'b0};
    tab[6] = '{2'd3, 4'd5,  15'($urandom_range(0, 31)),    1'b1, 1'b1};
    tab[7] = '{2'd2, 4'd15, 15'h7fff, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_d", 32'(if4.d), 32'd0);
    chk("rst_p", 32'(if4.p), 32'd0);
    chk("rst_valid", 32'(if4.outValid), 32'd0);
    chk("rst_error", 32'(if4.error), 32'd0);
    chk("rst_frame_done", 32'(if4.frame_done), 32'd0);
    chk("rst_busy", 32'(if4.busy), 32'd0);
    chk("rst_state", 32'(if4.state), 32'(IDLE));
    chk("rst_u3_busy", 32'(if3.busy), 32'd0);

    @(negedge clk);
    rst = 1'b1;
    idle(2);
    sb_en = 1'b1;

    // Table frames are sent with no idle bit between them.
    for (int i = 0; i < 8; i++)
      send_frame(0, tab[i].addr, tab[i].n, tab[i].pay, tab[i].bad_par, tab[i].exp_err);
    idle(3);

    // Three-channel instance: address 3 is out of range, address 2 is not.
    send_frame(1, 2'd3, 4'd2, 15'b10, 1'b0, 1'b1);
    send_frame(1, 2'd2, 4'd1, 15'b1,  1'b0, 1'b0);
    idle(2);

    // Reset during the payload of frame 1 must abort without strobes.
    sb_en = 1'b0;
    begin
      logic pre[8];
      pre = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
        if4.serIn = pre[i];
        @(posedge clk);
        #1;
      end
    end
    chk("pre_rst_valid", 32'(if4.outValid), 32'd1);
    chk("pre_rst_state", 32'(if4.state), 32'(DATA));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if4.outValid), 32'd0);
    chk("mid_rst_p", 32'(if4.p), 32'd0);
    chk("mid_rst_busy", 32'(if4.busy), 32'd0);
    chk("mid_rst_d", 32'(if4.d), 32'd0);
    chk("mid_rst_state", 32'(if4.state), 32'(IDLE));
    if4.serIn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    vcount = 0;
    sb_en = 1'b1;
    idle(2);
    send_frame(0, 2'd1, 4'd3, 15'b101, 1'b0, 1'b0);
    idle(3);

    chk("data_q_empty", 32'(data_exp_q.size()), 32'd0);
    chk("frame_q_empty", 32'(frame_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mssd_param.md
Name: mssd_param

Overview:
Parametrised successor to the fixed 4-port serial demultiplexer. It takes a single-bit framed serial stream and decodes start bit, destination address and length field. The n payload bits are steered, one per clock, to a one-hot output channel. New over the fixed block: configurable channel count and length width, optional even-parity trailer, out-of-range address detection and a frame_done strobe. It sits between the serial line receiver and per-channel consumers.

Parameters:
NUM_CH, 4, number of output channels (>=2)
ADDR_W, $clog2(NUM_CH), address field width; derived, not overridden
LEN_W, 4, payload length field width; max payload 2^LEN_W-1 bits
PARITY_EN, 1, 1 = frame ends with one even-parity bit; 0 = no trailer

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous active-low reset
serIn  input  1  serial line, idle high
d  output  ADDR_W  destination address of current/last frame
p  output  NUM_CH  one-hot data output; p[d] carries current payload bit, others 0
outValid  output  1  p holds a valid payload bit this cycle
error  output  1  one-cycle pulse: parity mismatch or address >= NUM_CH
frame_done  output  1  one-cycle pulse at end of every completed frame
busy  output  1  high from start-bit sample until frame end

Behaviour:
- Reset (rst=0, async): state IDLE; d, p, outValid, error, frame_done, busy all 0; counters and parity accumulator cleared. Reset mid-frame aborts the frame silently: no error, no frame_done.
- Frame format, MSB first: start bit 0, ADDR_W address bits, LEN_W length bits n, n payload bits, then parity bit if PARITY_EN. Even parity covers address, length and payload; the parity bit makes the total count of ones even.
- IDLE: serIn=1 stays. serIn=0 -> ADDR, busy=1 next cycle.
- ADDR: shift ADDR_W bits; on last -> LEN. d updates when the last address bit is captured.
- LEN: shift LEN_W bits; on last -> DATA if n>0, else PAR (PARITY_EN=1) or END.
- DATA: each edge samples one payload bit. The next cycle has p[d]=bit and outValid=1, i.e. 1-cycle latency. After the n-th bit -> PAR or END. outValid is continuous across the n bits.
- Out-of-range address (d >= NUM_CH, only possible when NUM_CH is not a power of 2): payload is consumed with p=0 and outValid=0.
- PAR: the edge samples the parity bit -> END.
- END: single-cycle behaviour folded into the last sampling edge. The next cycle has frame_done=1 and busy=0. error=1 in the same cycle if parity failed (PARITY_EN=1) or the address was out of range. The FSM is back in IDLE, so a start bit in the very next cycle is accepted: zero-gap back-to-back frames.
- Outside DATA, p=0 and outValid=0. d holds its value until the next address capture.
- error and frame_done are registered pulses, exactly 1 cycle wide.
- Counter width is max(ADDR_W, LEN_W). The length counter counts down and never wraps. A length of all ones gives 2^LEN_W-1 payload bits.

Decomposition:
- Package mssd_pkg: state enum {IDLE, ADDR, LEN, DATA, PAR}; function for counter width max(ADDR_W, LEN_W).
- One sub-module, mssd_frame_counter: loadable down-counter with terminal-count flag, reused for the field and payload phases.
- Parity accumulator, shift register and output steering stay in the top.

Test Plan:
1. NUM_CH=4, LEN_W=4. Serial 0,0,1,0,0,1,1,1,0,1, parity 1 (addr 01, n=3, payload 101). Required: d=01; p[1] = 1,0,1 on three consecutive cycles with outValid=1; then frame_done=1, error=0.
2. Same frame with parity bit 0 -> identical payload output; frame_done=1 and error=1 in the same cycle.
3. Addr 10, n=0, parity 1 -> no outValid cycle; frame_done one cycle after the parity edge; error=0; d=10.
4. Two back-to-back frames with no idle bit: addr 11 n=1 payload 1, then addr 00 n=2 payload 11. Required: p[3]=1 for 1 cycle, then p[0]=1 for 2 cycles; two frame_done pulses; no error.
5. NUM_CH=3 (ADDR_W=2), frame to addr 11, n=2 -> p stays 0 and outValid stays 0; frame_done=1, error=1.
6. Drive rst=0 during the DATA phase of frame 1 -> all outputs 0 immediately. After release, a fresh frame 1 decodes correctly with no spurious error or frame_done.
